// File: rtl/signed_restoring_divider.sv
// Signed restoring divider (two's complement, truncating toward zero).
//
// Operands are captured on the edge that accepts i_start. The divider
// converts them to magnitudes, runs DATA_WIDTH restoring iterations, and
// then applies the signs. The remainder takes the sign of the dividend.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset (release is synchronized)
//   i_start        division request, sampled only in IDLE
//   i_dividend     signed dividend
//   i_divisor      signed divisor
//   o_quotient     signed quotient (held until the next SIGN state)
//   o_remainder    signed remainder (held until the next SIGN state)
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse when the results are valid
//   o_div_by_zero  divisor was zero (valid with o_done)
//   o_overflow     most-negative / -1 (valid with o_done)
module signed_restoring_divider #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_div_by_zero,
  output logic                  o_overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q, sync_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W:0]     a_q, a_d;
  logic [W-1:0]   q_q, q_d;
  logic [W:0]     m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;
  logic           ov_q, ov_d;
  logic           done_q, done_d;

  // Datapath helpers
  logic           dvd_neg, dvs_neg;
  logic [W-1:0]   abs_dvd, abs_dvs;
  logic [W:0]     a_sh;
  logic [W-1:0]   q_sh;
  logic [W+1:0]   diff;
  logic [W-1:0]   a_lo;

  always_comb begin
    dvd_neg = dvd_q[W-1];
    dvs_neg = dvs_q[W-1];
    // Magnitudes as unsigned W-bit values: the most-negative operand maps
    // to 2^(W-1), which still fits without loss.
    abs_dvd = dvd_neg ? (~dvd_q + 1'b1) : dvd_q;
    abs_dvs = dvs_neg ? (~dvs_q + 1'b1) : dvs_q;
    // Shift {A,Q} left by one. A < M <= 2^(W-1), so A's top bit is never lost.
    a_sh    = {a_q[W-1:0], q_q[W-1]};
    q_sh    = {q_q[W-2:0], 1'b0};
    // One extra bit so the sign of A_shifted - M is visible directly.
    diff    = {1'b0, a_sh} - {1'b0, m_q};
    a_lo    = a_q[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], 1'b1};
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    done_d  = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        // Starts are held off until the reset release has passed the
        // two-stage synchronizer.
        if (i_start && sync_q[1]) begin
          dvd_d   = i_dividend;
          dvs_d   = i_divisor;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d     = '0;
        q_d     = abs_dvd;
        m_d     = {1'b0, abs_dvs};
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!diff[W+1]) begin
          a_d = diff[W:0];
          q_d = {q_sh[W-1:1], 1'b1};
        end else begin
          a_d = a_sh;
          q_d = q_sh;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        dz_d = (dvs_q == '0);
        ov_d = (dvd_q == {1'b1, {(W-1){1'b0}}}) && (dvs_q == '1);
        if (dvs_q == '0) begin
          quo_d = '1;
          rem_d = dvd_q;
        end else begin
          quo_d = (dvd_neg ^ dvs_neg) ? (~q_q + 1'b1) : q_q;
          rem_d = dvd_neg ? (~a_lo + 1'b1) : a_lo;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign o_quotient    = quo_q;
  assign o_remainder   = rem_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_div_by_zero = dz_q;
  assign o_overflow    = ov_q;

endmodule

// File: tb/tb_signed_restoring_divider.sv
// Testbench for signed_restoring_divider (DATA_WIDTH = 4): directed cases
// followed by random operands, each compared with an arithmetic model.
module tb_signed_restoring_divider;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [3:0] i_dividend;
  logic [3:0] i_divisor;
  logic [3:0] o_quotient;
  logic [3:0] o_remainder;
  logic       o_busy;
  logic       o_done;
  logic       o_div_by_zero;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;

  signed_restoring_divider #(.DATA_WIDTH(4)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_div_by_zero (o_div_by_zero),
    .o_overflow    (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncating, remainder follows the
  // dividend), plus the two special cases.
  task automatic model(input int a, input int b,
                       output logic [3:0] q, output logic [3:0] r,
                       output logic dz, output logic ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = 4'hF;
      r  = 4'(a);
    end else if (a == -8 && b == -1) begin
      ov = 1'b1;
      q  = 4'(-8);
      r  = 4'd0;
    end else begin
      q  = 4'(a / b);
      r  = 4'(a % b);
    end
  endtask

  task automatic run_div(input int a, input int b, input bit inject);
    logic [3:0] eq, er;
    logic       edz, eov;
    logic [3:0] gq, gr;
    logic       gdz, gov, gbusy_after, busy0;
    int         first, pulses;
    string      t;
    model(a, b, eq, er, edz, eov);
    t = $sformatf("%0d/%0d", a, b);
    gq = 'x; gr = 'x; gdz = 1'bx; gov = 1'bx; gbusy_after = 1'bx;
    i_dividend = 4'(a);
    i_divisor  = 4'(b);
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    i_start    = 1'b0;
    busy0      = o_busy;
    i_dividend = 4'($urandom_range(0, 15));
    i_divisor  = 4'($urandom_range(0, 15));
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      if (inject && k == 2) begin
        i_dividend = 4'd1;
        i_divisor  = 4'd1;
        i_start    = 1'b1;
      end
      if (inject && k == 3) i_start = 1'b0;
      @(posedge i_clk); #1;
      if (o_done) begin
        pulses++;
        if (first < 0) begin
          first = k;
          gq = o_quotient; gr = o_remainder; gdz = o_div_by_zero; gov = o_overflow;
        end
      end
      if (first >= 0 && k == first + 1) gbusy_after = o_busy;
    end
    check({t, " busy"},       32'(busy0), 32'd1);
    check({t, " latency"},    32'(first), 32'd7);
    check({t, " pulses"},     32'(pulses), 32'd1);
    check({t, " quotient"},   32'(gq), 32'(eq));
    check({t, " remainder"},  32'(gr), 32'(er));
    check({t, " div0"},       32'(gdz), 32'(edz));
    check({t, " overflow"},   32'(gov), 32'(eov));
    check({t, " busy_after"}, 32'(gbusy_after), 32'd0);
  endtask

  initial begin
    int dones;
    i_rst_n    = 1'b1;
    i_start    = 1'b0;
    i_dividend = 4'd0;
    i_divisor  = 4'd0;
    #2 i_rst_n = 1'b0;
    #1;
    check("reset quotient",  32'(o_quotient), 32'd0);
    check("reset remainder", 32'(o_remainder), 32'd0);
    check("reset busy",      32'(o_busy), 32'd0);
    check("reset done",      32'(o_done), 32'd0);
    check("reset flags",     32'({o_div_by_zero, o_overflow}), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;

    run_div(7, 2, 1'b0);
    run_div(-7, 2, 1'b0);
    run_div(7, -2, 1'b0);
    run_div(-8, -1, 1'b0);
    run_div(-8, 2, 1'b0);
    run_div(5, 0, 1'b0);
    run_div(-8, 0, 1'b0);
    run_div(6, 3, 1'b1);

    // Reset in the middle of an iteration aborts the division.
    i_dividend = 4'd7;
    i_divisor  = 4'd2;
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("abort quotient",  32'(o_quotient), 32'd0);
    check("abort remainder", 32'(o_remainder), 32'd0);
    check("abort busy",      32'(o_busy), 32'd0);
    check("abort done",      32'(o_done), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    run_div(4, 2, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int a, b;
      a = int'($urandom_range(0, 15)) - 8;
      b = int'($urandom_range(0, 15)) - 8;
      run_div(a, b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_restoring_divider.md
SIGNED_RESTORING_DIVIDER -- requirements
Module: signed_restoring_divider

Interface
REQ-001 Parameter: DATA_WIDTH, 4, operand/result width in bits (two's complement).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: i_clk  input  1  rising-edge clock for all state.
REQ-004 Port: i_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: i_start  input  1  request a division; sampled only in IDLE.
REQ-006 Port: i_dividend  input  DATA_WIDTH  signed dividend; captured on the edge that accepts i_start.
REQ-007 Port: i_divisor  input  DATA_WIDTH  signed divisor; captured on the same edge.
REQ-008 Port: o_quotient  output  DATA_WIDTH  signed quotient, truncated toward zero.
REQ-009 Port: o_remainder  output  DATA_WIDTH  signed remainder; sign follows the dividend.
REQ-010 Port: o_busy  output  1  high in every state except IDLE.
REQ-011 Port: o_done  output  1  single-cycle pulse when results are valid.
REQ-012 Port: o_div_by_zero  output  1  divisor was zero; valid with o_done.
REQ-013 Port: o_overflow  output  1  true quotient is not representable (most-negative / -1); valid with o_done.

Function
REQ-014 FSM states: IDLE, LOAD, ITER, SIGN, DONE; all registered, encoding free.
REQ-015 IDLE -> LOAD when i_start=1; otherwise stays in IDLE. Operands and operand signs latch on that edge.
REQ-016 LOAD: A (DATA_WIDTH+1 bits) <= 0; Q <= |dividend|; M (DATA_WIDTH+1 bits) <= |divisor| zero-extended; iteration counter <= 0; next state ITER.
REQ-017 ITER, one iteration per cycle: shift {A,Q} left by 1; T = A_shifted - M; if T >= 0, A <= T and Q[0] <= 1; else A is restored and Q[0] <= 0.
REQ-018 The counter increments once per ITER cycle; ITER -> SIGN after exactly DATA_WIDTH iterations.
REQ-019 SIGN: o_quotient <= -Q when the operand signs differ, else Q; o_remainder <= -A[DATA_WIDTH-1:0] when the dividend is negative, else A; both wrap modulo 2^DATA_WIDTH. Flags are registered here. Next state DONE.
REQ-020 DONE: o_done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 Latency: o_done is high in the cycle after the (DATA_WIDTH+3)th rising edge following the accepting edge, counting the accepting edge as edge 0 (edge 7 for DATA_WIDTH=4). Latency is fixed for all operands.
REQ-022 i_start is ignored while o_busy=1; there is no queuing and in-flight operands are not disturbed.
REQ-023 Divisor = 0: latency unchanged; o_div_by_zero=1; o_quotient = all ones; o_remainder = dividend.
REQ-024 Dividend = -2^(DATA_WIDTH-1) with divisor = -1: o_overflow=1; o_quotient = -2^(DATA_WIDTH-1) (wrapped); o_remainder = 0.
REQ-025 The most-negative dividend magnitude is represented correctly in the (DATA_WIDTH+1)-bit datapath; for example, -8/2 yields -4 with remainder 0.
REQ-026 o_quotient, o_remainder, o_div_by_zero, and o_overflow hold their values from SIGN until the next SIGN state.
REQ-027 o_busy is a pure decode of state and is high in LOAD, ITER, SIGN, and DONE.

Reset
REQ-028 While i_rst_n=0: FSM = IDLE; A, Q, M, and counter = 0; all outputs = 0. This applies immediately, asynchronously to i_clk.
REQ-029 Reset asserted mid-operation aborts the division; no o_done is produced for it. After release, the next i_start is accepted normally.
REQ-030 Reset deassertion is synchronized internally so that the FSM first leaves IDLE no earlier than the second rising edge after release.

Verification
REQ-031 Start with 7 / 2 -> o_done on edge 7 with quotient 4'b0011 (3), remainder 4'b0001 (1), and both flags 0.
REQ-032 Start with -7 / 2 -> quotient 4'b1101 (-3) and remainder 4'b1111 (-1). Start with 7 / -2 -> quotient 4'b1101 (-3) and remainder 4'b0001 (1).
REQ-033 Start with -8 / -1 -> quotient 4'b1000, remainder 0, o_overflow=1. Start with -8 / 2 -> quotient 4'b1100 (-4), remainder 0, o_overflow=0.
REQ-034 Start with 5 / 0 -> o_done still on edge 7; o_div_by_zero=1, quotient 4'b1111, remainder 4'b0101.
REQ-035 Start with 6 / 3, then pulse i_start with 1 / 1 during ITER -> only one o_done pulse, with quotient 2 and remainder 0; o_busy is low in the cycle after DONE.
REQ-036 Start with 7 / 2, assert i_rst_n=0 during ITER -> outputs are 0 at once and no o_done; after release, start 4 / 2 -> quotient 2, remainder 0.
